dsi_hs_multilane_tx: RTL and testbench

- Parametrised successor to the single-lane DSI high-speed lane sequencer.
- Drives 1..LANES data lanes, or one clock lane, through HS-GO, SYNC, ACTIVE and TRAIL from one FSM, emitting per-lane parallel bytes and output enables to external serialisers.
- Adds runtime-programmable HS-zero/trail timing, a partial final beat with per-lane early trail, and an abort path.
- Sits between the packet assembler (byte source) and the per-lane serdes/HS buffers.

---
 rtl/dsi_hs_multilane_tx_if.sv | 32 +++
 rtl/dsi_hs_multilane_tx.sv | 129 ++++++++++++
 tb/tb_dsi_hs_multilane_tx.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsi_hs_multilane_tx_if.sv
// Byte-source / serdes-facing bundle of the multi-lane DSI HS lane sequencer.
// The master drives requests, beats and timing; the slave (sequencer) returns handshakes and lane outputs.
interface dsi_hs_multilane_tx_if #(
  parameter int LANES = 4,
  parameter int CNT_W = 8,
  parameter int LL_W  = 3
);
  logic                 start_rqst;
  logic                 fin_rqst;
  logic                 abort_rqst;
  logic [8*LANES-1:0]   inp_data;
  logic [LL_W-1:0]      inp_last_lanes;
  logic [CNT_W-1:0]     cfg_go_cnt;
  logic [CNT_W-1:0]     cfg_trail_cnt;
  logic                 data_rqst;
  logic                 active;
  logic                 fin_ack;
  logic [8*LANES-1:0]   lane_data;
  logic [LANES-1:0]     lane_oe;

  modport master (
    output start_rqst, fin_rqst, abort_rqst, inp_data, inp_last_lanes,
           cfg_go_cnt, cfg_trail_cnt,
    input  data_rqst, active, fin_ack, lane_data, lane_oe
  );

  modport slave (
    input  start_rqst, fin_rqst, abort_rqst, inp_data, inp_last_lanes,
           cfg_go_cnt, cfg_trail_cnt,
    output data_rqst, active, fin_ack, lane_data, lane_oe
  );
endinterface

// File: rtl/dsi_hs_multilane_tx.sv
// DSI high-speed lane sequencer for 1..LANES data lanes or a single clock lane.
// One FSM walks HS-GO, SYNC, ACTIVE and TRAIL with programmable go/trail lengths.
//
//   state  | meaning
//   IDLE   | lanes off, waiting for start_rqst
//   GO     | HS-zero, cfg_go_cnt+1 cycles
//   SYNC   | one sync byte per lane (data lanes only)
//   ACTIVE | payload beats (data) or 0x55 toggling (clock lane)
//   TRAIL  | trail bytes, cfg_trail_cnt+1 cycles, fin_ack on last
module dsi_hs_multilane_tx #(
  parameter int LANES = 4,
  parameter int MODE  = 0,
  parameter int CNT_W = 8,
  parameter int LL_W  = 3
) (
  input logic                  clk_sys,
  input logic                  rst_n,
  dsi_hs_multilane_tx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    GO,
    SYNC,
    ACTIVE,
    TRAIL
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'b0001_1101;
  localparam logic [7:0] CLK_BYTE  = 8'b0101_0101;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic                    cnt_zero;
  logic                    data_rqst_q;
  logic                    active_q;
  logic [LANES-1:0][7:0]   trail_byte;
  logic [LANES-1:0][7:0]   lane_byte;
  logic [LL_W-1:0]         last_eff;
  logic [LANES-1:0]        lane_vld;

  assign cnt_zero = (cnt == '0);

  // Out-of-range lane counts on the final beat mean "all lanes valid".
  always_comb begin
    last_eff = bus.inp_last_lanes;
    if (bus.inp_last_lanes == '0 || bus.inp_last_lanes > LL_W'(LANES))
      last_eff = LL_W'(LANES);
  end

  always_comb begin
    lane_vld = '1;
    for (int i = 0; i < LANES; i++) begin
      if (state == ACTIVE && bus.fin_rqst && i >= int'(last_eff))
        lane_vld[i] = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_rqst) state_nxt = GO;
      GO:      if (cnt_zero) state_nxt = (MODE == 1) ? ACTIVE : SYNC;
      SYNC:    state_nxt = ACTIVE;
      ACTIVE:  if (bus.fin_rqst) state_nxt = TRAIL;
      TRAIL:   if (cnt_zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.abort_rqst && state != IDLE)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      data_rqst_q <= 1'b0;
      active_q    <= 1'b0;
      trail_byte  <= '0;
    end else begin
      state <= state_nxt;
      // Config is captured only at the load points; the counter just runs down afterwards.
      if (state == IDLE && state_nxt == GO)
        cnt <= bus.cfg_go_cnt;
      else if (state == ACTIVE && state_nxt == TRAIL)
        cnt <= bus.cfg_trail_cnt;
      else if (state == GO || state == TRAIL)
        cnt <= cnt - 1'b1;
      data_rqst_q <= (state_nxt == SYNC) || (state_nxt == ACTIVE);
      if (state_nxt == ACTIVE)
        active_q <= 1'b1;
      else if (state_nxt == IDLE)
        active_q <= 1'b0;
      if (state == ACTIVE) begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_vld[i])
            trail_byte[i] <= {8{~bus.inp_data[8*i+7]}};
        end
      end
    end
  end

  always_comb begin
    lane_byte = '0;
    for (int i = 0; i < LANES; i++) begin
      case (state)
        SYNC:    lane_byte[i] = SYNC_BYTE;
        ACTIVE: begin
          if (MODE == 1)
            lane_byte[i] = CLK_BYTE;
          else if (lane_vld[i])
            lane_byte[i] = bus.inp_data[8*i +: 8];
          else
            lane_byte[i] = trail_byte[i];
        end
        TRAIL:   lane_byte[i] = (MODE == 1) ? 8'h00 : trail_byte[i];
        default: lane_byte[i] = 8'h00;
      endcase
    end
  end

  assign bus.lane_data = lane_byte;
  assign bus.lane_oe   = {LANES{state != IDLE}};
  assign bus.fin_ack   = (state == TRAIL) && cnt_zero;
  assign bus.data_rqst = data_rqst_q;
  assign bus.active    = active_q;

endmodule

// File: tb/tb_dsi_hs_multilane_tx.sv
// Scoreboard bench: each burst builder pushes per-cycle stimulus and expected outputs,
// play() drives and records, and each test task pops and compares.
module tb_dsi_hs_multilane_tx;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  dsi_hs_multilane_tx_if #(.LANES(4), .CNT_W(8), .LL_W(3)) bus0 ();
  dsi_hs_multilane_tx_if #(.LANES(1), .CNT_W(8), .LL_W(1)) bus1 ();

  dsi_hs_multilane_tx #(.LANES(4), .MODE(0), .CNT_W(8), .LL_W(3)) dut0 (
    .clk_sys(clk_sys), .rst_n(rst_n), .bus(bus0)
  );
  dsi_hs_multilane_tx #(.LANES(1), .MODE(1), .CNT_W(8), .LL_W(1)) dut1 (
    .clk_sys(clk_sys), .rst_n(rst_n), .bus(bus1)
  );

  typedef struct packed {
    logic        start;
    logic        fin;
    logic        abort;
    logic [31:0] data;
    logic [2:0]  last;
    logic [7:0]  go;
    logic [7:0]  tr;
  } stim_t;

  typedef struct packed {
    logic [31:0] ld;
    logic [3:0]  oe;
    logic        dr;
    logic        act;
    logic        fa;
  } obs_t;

  stim_t       sq[$];
  obs_t        eq[$];
  obs_t        oq[$];
  logic [31:0] bq[$];
  logic [7:0]  tr_m[4];
  bit          sel = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic stim_t idle_stim();
    stim_t s;
    s    = '0;
    s.go = 8'($urandom);
    s.tr = 8'($urandom);
    return s;
  endfunction

  task automatic add_idle(input int n);
    for (int k = 0; k < n; k++) begin
      sq.push_back(idle_stim());
      eq.push_back('0);
    end
  endtask

  // ab_mode: 0 normal fin, 1 abort on last beat, 2 fin+abort on last beat
  task automatic add_burst(input int g, input int t, input int last_l, input bit m1,
                           input int ab_mode, input bit hold_st, input bit fin_go);
    stim_t      s;
    obs_t       e;
    int         lanes;
    int         eff;
    logic [3:0] oea;
    bit         fin;
    lanes = m1 ? 1 : 4;
    oea   = m1 ? 4'h1 : 4'hF;
    eff   = (last_l == 0 || last_l > lanes) ? lanes : last_l;
    s = idle_stim(); s.start = 1'b1; s.go = 8'(g);
    sq.push_back(s); eq.push_back('0);
    for (int k = 0; k <= g; k++) begin
      s = idle_stim(); s.start = hold_st; s.fin = fin_go;
      e = '0; e.oe = oea;
      sq.push_back(s); eq.push_back(e);
    end
    if (!m1) begin
      s = idle_stim(); s.start = hold_st;
      e = '0; e.oe = oea; e.dr = 1'b1;
      for (int i = 0; i < 4; i++) e.ld[8*i +: 8] = 8'h1D;
      sq.push_back(s); eq.push_back(e);
    end
    for (int b = 0; b < bq.size(); b++) begin
      fin = (b == bq.size() - 1) && (ab_mode != 1);
      s = idle_stim(); s.start = hold_st; s.fin = fin; s.data = bq[b]; s.last = 3'(last_l);
      s.abort = (b == bq.size() - 1) && (ab_mode != 0);
      if (fin) s.tr = 8'(t);
      e = '0; e.oe = oea; e.dr = 1'b1; e.act = 1'b1;
      for (int i = 0; i < lanes; i++) begin
        if (m1) begin
          e.ld[7:0] = 8'h55;
        end else if (!fin || i < eff) begin
          e.ld[8*i +: 8] = bq[b][8*i +: 8];
          tr_m[i] = {8{~bq[b][8*i+7]}};
        end else begin
          e.ld[8*i +: 8] = tr_m[i];
        end
      end
      sq.push_back(s); eq.push_back(e);
    end
    if (ab_mode == 0) begin
      for (int k = 0; k <= t; k++) begin
        s = idle_stim(); s.start = hold_st;
        e = '0; e.oe = oea; e.act = 1'b1; e.fa = (k == t);
        if (!m1) for (int i = 0; i < 4; i++) e.ld[8*i +: 8] = tr_m[i];
        sq.push_back(s); eq.push_back(e);
      end
    end
  endtask

  task automatic play(input int n);
    stim_t s;
    obs_t  o;
    for (int k = 0; k < n; k++) begin
      s = sq.pop_front();
      @(posedge clk_sys); #1;
      bus0.start_rqst     = sel ? 1'b0 : s.start;
      bus0.fin_rqst       = sel ? 1'b0 : s.fin;
      bus0.abort_rqst     = sel ? 1'b0 : s.abort;
      bus0.inp_data       = sel ? 32'h0 : s.data;
      bus0.inp_last_lanes = sel ? 3'h0 : s.last;
      bus0.cfg_go_cnt     = s.go;
      bus0.cfg_trail_cnt  = s.tr;
      bus1.start_rqst     = sel ? s.start : 1'b0;
      bus1.fin_rqst       = sel ? s.fin : 1'b0;
      bus1.abort_rqst     = sel ? s.abort : 1'b0;
      bus1.inp_data       = sel ? s.data[7:0] : 8'h0;
      bus1.inp_last_lanes = sel ? s.last[0] : 1'b0;
      bus1.cfg_go_cnt     = s.go;
      bus1.cfg_trail_cnt  = s.tr;
      @(negedge clk_sys);
      if (sel) begin
        o.ld = {24'h0, bus1.lane_data}; o.oe = {3'b0, bus1.lane_oe};
        o.dr = bus1.data_rqst; o.act = bus1.active; o.fa = bus1.fin_ack;
      end else begin
        o.ld = bus0.lane_data; o.oe = bus0.lane_oe;
        o.dr = bus0.data_rqst; o.act = bus0.active; o.fa = bus0.fin_ack;
      end
      oq.push_back(o);
    end
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (bus0.lane_data !== 32'h0) $display("FAIL reset_ld0 got %h want 0", bus0.lane_data); else n_pass++;
    n_chk++; if (bus0.lane_oe !== 4'h0) $display("FAIL reset_oe0 got %h want 0", bus0.lane_oe); else n_pass++;
    n_chk++; if ({bus0.data_rqst, bus0.active, bus0.fin_ack} !== 3'b000)
      $display("FAIL reset_flags0 got %b want 000", {bus0.data_rqst, bus0.active, bus0.fin_ack}); else n_pass++;
    n_chk++; if ({bus1.lane_data, bus1.lane_oe, bus1.data_rqst, bus1.active, bus1.fin_ack} !== 12'h0)
      $display("FAIL reset_dut1 got %h want 0", {bus1.lane_data, bus1.lane_oe, bus1.data_rqst, bus1.active, bus1.fin_ack});
    else n_pass++;
    @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    obs_t e, o;
    int   cyc = 0;
    bq.delete(); bq.push_back(32'hA1B2C3D4); bq.push_back(32'h8800_0F70);
    add_burst(2, 2, 4, 1'b0, 0, 1'b0, 1'b0);
    add_idle(2);
    play(sq.size());
    while (oq.size() > 0 && eq.size() > 0) begin
      e = eq.pop_front(); o = oq.pop_front(); n_chk++;
      if (o !== e) $display("FAIL basic cyc%0d got %h want %h", cyc, o, e); else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_partial();
    obs_t e, o;
    int   cyc = 0;
    bq.delete(); bq.push_back(32'h8080_8080); bq.push_back(32'h1234_5601);
    add_burst(1, 1, 1, 1'b0, 0, 1'b0, 1'b0);
    add_idle(1);
    bq.delete(); bq.push_back(32'h0F80_7F01); bq.push_back(32'hAA55_CC33);
    add_burst(0, 2, 2, 1'b0, 0, 1'b0, 1'b0);
    add_idle(1);
    play(sq.size());
    while (oq.size() > 0 && eq.size() > 0) begin
      e = eq.pop_front(); o = oq.pop_front(); n_chk++;
      if (o !== e) $display("FAIL partial cyc%0d got %h want %h", cyc, o, e); else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_last_clamp();
    obs_t e, o;
    int   cyc = 0;
    bq.delete(); bq.push_back(32'h7F80_017F);
    add_burst(1, 1, 0, 1'b0, 0, 1'b0, 1'b0);
    bq.delete(); bq.push_back(32'h0000_0000); bq.push_back(32'h8001_FF80);
    add_burst(1, 0, 7, 1'b0, 0, 1'b0, 1'b0);
    add_idle(1);
    play(sq.size());
    while (oq.size() > 0 && eq.size() > 0) begin
      e = eq.pop_front(); o = oq.pop_front(); n_chk++;
      if (o !== e) $display("FAIL clamp cyc%0d got %h want %h", cyc, o, e); else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_timing_extremes();
    obs_t e, o;
    int   cyc = 0;
    bq.delete(); bq.push_back(32'h1122_3344);
    add_burst(0, 0, 4, 1'b0, 0, 1'b0, 1'b0);
    add_idle(1);
    bq.delete(); bq.push_back(32'hC0FF_EE00); bq.push_back(32'h0102_0304);
    add_burst(255, 255, 4, 1'b0, 0, 1'b0, 1'b0);
    add_idle(2);
    play(sq.size());
    while (oq.size() > 0 && eq.size() > 0) begin
      e = eq.pop_front(); o = oq.pop_front(); n_chk++;
      if (o !== e) $display("FAIL timing cyc%0d got %h want %h", cyc, o, e); else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_mode1();
    obs_t e, o;
    int   cyc = 0;
    sel = 1'b1;
    bq.delete(); bq.push_back(32'h0000_00FF); bq.push_back(32'h0000_0000); bq.push_back(32'h0000_00A7);
    add_burst(1, 1, 1, 1'b1, 0, 1'b0, 1'b0);
    add_idle(1);
    bq.delete(); bq.push_back(32'h0000_0012);
    add_burst(0, 0, 0, 1'b1, 0, 1'b0, 1'b0);
    add_idle(2);
    play(sq.size());
    sel = 1'b0;
    while (oq.size() > 0 && eq.size() > 0) begin
      e = eq.pop_front(); o = oq.pop_front(); n_chk++;
      if (o !== e) $display("FAIL mode1 cyc%0d got %h want %h", cyc, o, e); else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_abort();
    obs_t e, o;
    int   cyc = 0;
    bq.delete(); bq.push_back(32'h0102_0304); bq.push_back(32'h8899_AABB); bq.push_back(32'h5566_7788);
    add_burst(1, 3, 4, 1'b0, 1, 1'b0, 1'b0);
    add_idle(2);
    bq.delete(); bq.push_back(32'hDEAD_BEEF); bq.push_back(32'h0F0F_F0F0);
    add_burst(2, 2, 2, 1'b0, 2, 1'b0, 1'b0);
    add_idle(2);
    play(sq.size());
    while (oq.size() > 0 && eq.size() > 0) begin
      e = eq.pop_front(); o = oq.pop_front(); n_chk++;
      if (o !== e) $display("FAIL abort cyc%0d got %h want %h", cyc, o, e); else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_ignored();
    obs_t e, o;
    int   cyc = 0;
    bq.delete(); bq.push_back(32'h4433_2211); bq.push_back(32'hFFEE_DDCC);
    add_burst(3, 2, 4, 1'b0, 0, 1'b1, 1'b1);
    add_idle(3);
    play(sq.size());
    while (oq.size() > 0 && eq.size() > 0) begin
      e = eq.pop_front(); o = oq.pop_front(); n_chk++;
      if (o !== e) $display("FAIL ignored cyc%0d got %h want %h", cyc, o, e); else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    int   cyc = 0;
    bq.delete(); bq.push_back(32'hFFFF_0000); bq.push_back(32'h0000_8080);
    add_burst(1, 1, 2, 1'b0, 0, 1'b0, 1'b0);
    bq.delete(); bq.push_back(32'h1357_9BDF); bq.push_back(32'h8642_0ACE);
    add_burst(4, 3, 3, 1'b0, 0, 1'b0, 1'b0);
    add_idle(2);
    play(sq.size());
    while (oq.size() > 0 && eq.size() > 0) begin
      e = eq.pop_front(); o = oq.pop_front(); n_chk++;
      if (o !== e) $display("FAIL b2b cyc%0d got %h want %h", cyc, o, e); else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_async_reset();
    obs_t e, o;
    int   cyc = 0;
    bq.delete(); bq.push_back(32'h0080_8000);
    add_burst(1, 3, 4, 1'b0, 0, 1'b0, 1'b0);
    play(7);
    while (oq.size() > 0 && eq.size() > 0) begin
      e = eq.pop_front(); o = oq.pop_front(); n_chk++;
      if (o !== e) $display("FAIL arst_pre cyc%0d got %h want %h", cyc, o, e); else n_pass++;
      cyc++;
    end
    sq.delete(); eq.delete();
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({bus0.lane_data, bus0.lane_oe} !== 36'h0)
      $display("FAIL arst_lanes got %h want 0", {bus0.lane_data, bus0.lane_oe}); else n_pass++;
    n_chk++; if ({bus0.data_rqst, bus0.active, bus0.fin_ack} !== 3'b000)
      $display("FAIL arst_flags got %b want 000", {bus0.data_rqst, bus0.active, bus0.fin_ack}); else n_pass++;
    for (int i = 0; i < 4; i++) tr_m[i] = 8'h00;
    @(negedge clk_sys);
    rst_n = 1'b1;
    add_idle(2);
    bq.delete(); bq.push_back(32'h1111_1111); bq.push_back(32'h2222_2222);
    add_burst(0, 0, 1, 1'b0, 0, 1'b0, 1'b0);
    add_idle(1);
    play(sq.size());
    cyc = 0;
    while (oq.size() > 0 && eq.size() > 0) begin
      e = eq.pop_front(); o = oq.pop_front(); n_chk++;
      if (o !== e) $display("FAIL arst_post cyc%0d got %h want %h", cyc, o, e); else n_pass++;
      cyc++;
    end
  endtask

  initial begin
    bus0.start_rqst = 1'b0; bus0.fin_rqst = 1'b0; bus0.abort_rqst = 1'b0;
    bus0.inp_data = '0; bus0.inp_last_lanes = '0; bus0.cfg_go_cnt = '0; bus0.cfg_trail_cnt = '0;
    bus1.start_rqst = 1'b0; bus1.fin_rqst = 1'b0; bus1.abort_rqst = 1'b0;
    bus1.inp_data = '0; bus1.inp_last_lanes = '0; bus1.cfg_go_cnt = '0; bus1.cfg_trail_cnt = '0;
    for (int i = 0; i < 4; i++) tr_m[i] = 8'h00;
    test_reset();
    test_basic();
    test_partial();
    test_last_clamp();
    test_timing_extremes();
    test_mode1();
    test_abort();
    test_ignored();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
